sprite_pixel_gen: RTL and testbench

- Producer side of the colour-mapper interface: generates one sprite's per-pixel hit flag and 24-bit RGB for the current DrawX/DrawY.
- Owns the sprite ROM address path, frame-synchronous position latching, walk-cycle animation and transparency keying.
- One instance per sprite (mario, luigi, gomba, coin); outputs feed the mapper's hit/pixel input pairs.

---
 rtl/sprite_pkg.sv | 15 +
 rtl/sprite_anim_ctr.sv | 48 ++++
 rtl/sprite_pixel_gen.sv | 120 ++++++++++++
 tb/tb_sprite_pixel_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared colour/coordinate types and screen constants for the sprite pixel generators.
package sprite_pkg;
    typedef logic [23:0] rgb_t;
    typedef logic [9:0]  coord_t;

    localparam rgb_t KEY_COLOR = 24'hFF00FF;
    localparam int   SCREEN_W  = 640;
    localparam int   SCREEN_H  = 480;
    localparam int   GROUND_Y  = 416;

    // Index width that stays legal (>= 1 bit) even for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sprite_anim_ctr.sv
// sprite_anim_ctr: walk-cycle frame selector, stepping once every ANIM_DIV moving frame edges.
module sprite_anim_ctr
    import sprite_pkg::*;
#(
    parameter  int FRAMES   = 2,
    parameter  int ANIM_DIV = 8,
    localparam int FW       = idx_w(FRAMES)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          frame_edge_i,
    input  logic          moving_i,
    output logic [FW-1:0] frame_idx_o
);
    localparam int CW = idx_w(ANIM_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] idx_q, idx_d;

    // Only frame edges touch state, so the frame index never changes mid-frame.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (frame_edge_i) begin
            if (!moving_i) begin
                cnt_d = '0;
                idx_d = '0;
            end else if (cnt_q == CW'(ANIM_DIV - 1)) begin
                cnt_d = '0;
                idx_d = (idx_q == FW'(FRAMES - 1)) ? '0 : idx_q + FW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign frame_idx_o = idx_q;
endmodule

// File: rtl/sprite_pixel_gen.sv
// sprite_pixel_gen: per-sprite hit flag and RGB producer for the colour mapper.
// Horizontal mirroring on facing_left is built only when SPRITE_FLIP_EN is defined.
module sprite_pixel_gen
    import sprite_pkg::*;
#(
    parameter int SPR_W    = 32,
    parameter int SPR_H    = 32,
    parameter int FRAMES   = 2,
    parameter int ROM_LAT  = 1,
    parameter int ANIM_DIV = 8,
    parameter int ADDR_W   = 11
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              visible,
    input  logic              moving,
    input  logic              facing_left,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              hit,
    output logic [23:0]       pixel_out
);
    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);
    localparam int FW = idx_w(FRAMES);

    logic              fclk_q, frame_edge;
    coord_t            px_q, px_d, py_q, py_d;
    logic              vis_q, vis_d;
    logic [FW-1:0]     frame_idx;
    logic [10:0]       dx, dy, x0, y0;
    logic              in_box;
    logic [XW-1:0]     rel_x, rel_xm;
    logic [YW-1:0]     rel_y;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ROM_LAT:0]  box_q, box_d;
    logic              hit_q, hit_d;
    rgb_t              pix_q, pix_d;

    assign frame_edge = frame_clk & ~fclk_q;
    assign px_d       = frame_edge ? pos_x : px_q;
    assign py_d       = frame_edge ? pos_y : py_q;
    assign vis_d      = frame_edge ? visible : vis_q;

    sprite_anim_ctr #(
        .FRAMES   (FRAMES),
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .clk_i        (Clk),
        .rst_i        (Reset),
        .frame_edge_i (frame_edge),
        .moving_i     (moving),
        .frame_idx_o  (frame_idx)
    );

    // One extra bit keeps px+SPR_W from wrapping for sprites hanging off the right/bottom edge.
    assign dx     = {1'b0, DrawX};
    assign dy     = {1'b0, DrawY};
    assign x0     = {1'b0, px_q};
    assign y0     = {1'b0, py_q};
    assign in_box = (dx >= x0) && (dx < x0 + 11'(SPR_W)) && (dy >= y0) && (dy < y0 + 11'(SPR_H));
    assign rel_x  = XW'(DrawX - px_q);
    assign rel_y  = YW'(DrawY - py_q);

`ifdef SPRITE_FLIP_EN
    logic face_q, face_d;

    assign face_d = frame_edge ? facing_left : face_q;
    assign rel_xm = face_q ? ~rel_x : rel_x;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) face_q <= 1'b0;
        else       face_q <= face_d;
    end
`else
    logic unused_facing;

    assign unused_facing = facing_left;
    assign rel_xm        = rel_x;
`endif

    // Power-of-two sprite sizes make the concatenation equal frame*W*H + y*W + x.
    always_comb begin
        addr_d = in_box ? ADDR_W'({frame_idx, rel_y, rel_xm}) : addr_q;
        box_d  = {box_q[ROM_LAT-1:0], in_box & vis_q};
        hit_d  = box_q[ROM_LAT] && (rom_data != KEY_COLOR);
        pix_d  = hit_d ? rom_data : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fclk_q <= 1'b0;
            px_q   <= '0;
            py_q   <= '0;
            vis_q  <= 1'b0;
            addr_q <= '0;
            box_q  <= '0;
            hit_q  <= 1'b0;
            pix_q  <= '0;
        end else begin
            fclk_q <= frame_clk;
            px_q   <= px_d;
            py_q   <= py_d;
            vis_q  <= vis_d;
            addr_q <= addr_d;
            box_q  <= box_d;
            hit_q  <= hit_d;
            pix_q  <= pix_d;
        end
    end

    assign rom_addr  = addr_q;
    assign hit       = hit_q;
    assign pixel_out = pix_q;
endmodule

// File: tb/tb_sprite_pixel_gen.sv
// tb_sprite_pixel_gen: table vectors, directed corner sequences and random pixels against a frame-level model.
module tb_sprite_pixel_gen;
    localparam int SPR_W    = 32;
    localparam int SPR_H    = 32;
    localparam int FRAMES   = 2;
    localparam int ANIM_DIV = 8;
    localparam int IDLE     = 1023;
    localparam logic [23:0] KEY  = 24'hFF00FF;
    localparam logic [23:0] FILL = 24'h112233;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_clk = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
    logic        visible = 1'b0, moving = 1'b0, facing_left = 1'b0;
    logic [10:0] rom_addr;
    logic [23:0] rom_data = '0;
    logic        hit;
    logic [23:0] pixel_out;

    logic [23:0] rom [0:2047];

    sprite_pixel_gen #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .ROM_LAT(1), .ANIM_DIV(ANIM_DIV), .ADDR_W(11)
    ) dut (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
        .pos_x(pos_x), .pos_y(pos_y), .visible(visible), .moving(moving), .facing_left(facing_left),
        .rom_addr(rom_addr), .rom_data(rom_data), .hit(hit), .pixel_out(pixel_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct { bit h; logic [23:0] p; } exp_t;
    typedef struct { int x; int y; bit h; logic [23:0] pix; int addr; } vec_t;

    exp_t q[$];
    int   errors = 0, checks = 0;
    int   m_px, m_py, m_ticks, m_addr;
    bit   m_vis, m_face, m_fc_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        exp_t z;
        z.h = 1'b0;
        z.p = '0;
        q.delete();
        repeat (3) q.push_back(z);
        m_px = 0; m_py = 0; m_ticks = 0; m_addr = 0;
        m_vis = 1'b0; m_face = 1'b0; m_fc_prev = 1'b0;
    endtask

    // Called at a falling edge: check what the DUT shows now, then present a new pixel.
    task automatic step(input int x, input int y, input bit fc);
        exp_t e;
        bit   inb;
        int   idx;
        e = q.pop_front();
        chk("hit", 32'(hit), 32'(e.h));
        chk("pixel_out", 32'(pixel_out), 32'(e.p));
        chk("rom_addr", 32'(rom_addr), m_addr);
        frame_clk = fc;
        DrawX = x[9:0];
        DrawY = y[9:0];
        idx = (m_ticks / ANIM_DIV) % FRAMES;
        inb = x >= m_px && x < m_px + SPR_W && y >= m_py && y < m_py + SPR_H;
        if (inb) m_addr = idx * SPR_W * SPR_H + (y - m_py) * SPR_W + (m_face ? SPR_W - 1 - (x - m_px) : x - m_px);
        e.h = inb && m_vis && rom[m_addr] != KEY;
        e.p = e.h ? rom[m_addr] : 24'h0;
        q.push_back(e);
        if (fc && !m_fc_prev) begin
            m_px = int'(pos_x);
            m_py = int'(pos_y);
            m_vis = visible;
`ifdef SPRITE_FLIP_EN
            m_face = facing_left;
`endif
            m_ticks = moving ? m_ticks + 1 : 0;
        end
        m_fc_prev = fc;
        @(negedge clk);
    endtask

    task automatic frame_edge();
        step(IDLE, IDLE, 1'b1);
        step(IDLE, IDLE, 1'b0);
    endtask

    task automatic flush();
        repeat (3) step(IDLE, IDLE, 1'b0);
    endtask

    function automatic int clampi(input int v, input int hi);
        return v < 0 ? 0 : (v > hi ? hi : v);
    endfunction

    vec_t tv[9];
    int   cnt;

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = FILL;
        rom[5] = KEY;
        tv[0] = '{100, 200, 1'b1, FILL,  0};
        tv[1] = '{132, 200, 1'b0, 24'h0, 0};
        tv[2] = '{ 99, 200, 1'b0, 24'h0, 0};
        tv[3] = '{105, 200, 1'b0, 24'h0, 5};
        tv[4] = '{106, 200, 1'b1, FILL,  6};
        tv[5] = '{131, 231, 1'b1, FILL,  1023};
        tv[6] = '{131, 232, 1'b0, 24'h0, 1023};
        tv[7] = '{100, 199, 1'b0, 24'h0, 1023};
        tv[8] = '{110, 210, 1'b1, FILL,  330};

        pos_x = 10'd100; pos_y = 10'd200; visible = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_hit", 32'(hit), 0);
        chk("reset_pixel", 32'(pixel_out), 0);
        chk("reset_addr", 32'(rom_addr), 0);
        rst = 1'b0;
        reset_model();

        // No frame edge yet: nothing may hit anywhere on screen.
        cnt = 0;
        for (int y = 0; y < 480; y += 8)
            for (int x = 0; x < 640; x += 8) begin step(x, y, 1'b0); cnt += int'(hit); end
        for (int y = 195; y < 236; y++)
            for (int x = 90; x < 141; x++) begin step(x, y, 1'b0); cnt += int'(hit); end
        flush();
        cnt += int'(hit);
        chk("no_edge_hits", cnt, 0);

        frame_edge();
        for (int i = 0; i < 9; i++) begin
            step(tv[i].x, tv[i].y, 1'b0);
            chk($sformatf("tv%0d_addr", i), 32'(rom_addr), tv[i].addr);
            step(IDLE, IDLE, 1'b0);
            step(IDLE, IDLE, 1'b0);
            chk($sformatf("tv%0d_hit", i), 32'(hit), 32'(tv[i].h));
            chk($sformatf("tv%0d_pix", i), 32'(pixel_out), 32'(tv[i].pix));
        end

        // Sprite hanging off the right edge: only the on-screen 20 columns hit, no wrap to the next line.
        pos_x = 10'd620; pos_y = 10'd300;
        frame_edge();
        cnt = 0;
        for (int x = 600; x < 640; x++) begin step(x, 310, 1'b0); cnt += int'(hit); end
        for (int x = 0; x < 16; x++) begin step(x, 311, 1'b0); cnt += int'(hit); end
        repeat (3) begin step(IDLE, IDLE, 1'b0); cnt += int'(hit); end
        chk("right_edge_hits", cnt, 20);

        pos_x = 10'd100; pos_y = 10'd200; moving = 1'b1;
        for (int r = 0; r < 3; r++) begin
            repeat (ANIM_DIV) frame_edge();
            step(100, 200, 1'b0);
            chk($sformatf("anim%0d_addr", r), 32'(rom_addr), (r % 2 == 0) ? 1024 : 0);
        end
        moving = 1'b0;
        frame_edge();
        step(100, 200, 1'b0);
        chk("anim_stop_addr", 32'(rom_addr), 0);

`ifdef SPRITE_FLIP_EN
        facing_left = 1'b1;
        frame_edge();
        step(100, 200, 1'b0);
        chk("flip_addr", 32'(rom_addr), 31);
        step(131, 201, 1'b0);
        chk("flip_addr_r", 32'(rom_addr), 32);
        flush();
`endif

        flush();
        for (int i = 0; i < 2048; i++) rom[i] = ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom);
        for (int f = 0; f < 20; f++) begin
            pos_x = 10'(($urandom_range(0, 3) == 0) ? $urandom_range(600, 639) : $urandom_range(0, 639));
            pos_y = 10'(($urandom_range(0, 3) == 0) ? $urandom_range(450, 479) : $urandom_range(0, 479));
            visible = $urandom_range(0, 4) != 0;
            moving = 1'($urandom_range(0, 1));
            facing_left = 1'($urandom_range(0, 1));
            frame_edge();
            pos_x = 10'($urandom_range(0, 639));
            pos_y = 10'($urandom_range(0, 479));
            visible = 1'($urandom_range(0, 1));
            facing_left = 1'($urandom_range(0, 1));
            repeat (200)
                step(clampi(m_px - 8 + int'($urandom_range(0, 47)), 639),
                     clampi(m_py - 8 + int'($urandom_range(0, 47)), 479), 1'b0);
        end

        // Reset asserted mid-line must clear outputs without a clock edge.
        flush();
        for (int i = 0; i < 2048; i++) rom[i] = FILL;
        pos_x = 10'd100; pos_y = 10'd200; visible = 1'b1; moving = 1'b0; facing_left = 1'b0;
        frame_edge();
        for (int i = 0; i < 4; i++) step(100 + i, 200, 1'b0);
        chk("pre_reset_hit", 32'(hit), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_hit", 32'(hit), 0);
        chk("async_pixel", 32'(pixel_out), 0);
        chk("async_addr", 32'(rom_addr), 0);
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step(100 + i, 200, 1'b0);
        flush();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
